// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic-array tile scheduler.
//   state_t : scheduler FSM states
//   DEF_*   : default parameter values
//   sext()  : two's-complement sign extension of a w-bit value to 64 bits
package sys_array_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_GAP, S_START, S_WAIT, S_ACCUM, S_DONE
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ARRAY_W    = 5;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_LOAD_GAP   = 6;
  localparam int DEF_START_LEN  = 6;
  localparam int DEF_TIMEOUT    = 1024;

  // Mask to w bits, then flip-and-subtract the sign bit: yields the signed
  // value of the low w bits, valid for 1 <= w <= 64.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    logic [63:0] msk;
    m   = 64'd1 << (w - 1);
    msk = (m << 1) - 64'd1;
    return ((v & msk) ^ m) - m;
  endfunction

endpackage

// File: rtl/sys_array_accum.sv
// W x W accumulator bank. Each element adds the sign-extended array result
// element when add is high; clr zeroes the whole bank (clr wins over add).
// Sums wrap modulo 2^ACC_WIDTH.
//   clk, reset_n : clock, async active-low reset
//   clr, add     : bank clear / accumulate enables
//   in_data      : array result tile, 2*DATA_WIDTH bits per element
//   acc          : accumulated tile, ACC_WIDTH bits per element
module sys_array_accum
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_W    = DEF_ARRAY_W,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic add,
  input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] in_data,
  output logic [0:ARRAY_W-1][0:ARRAY_W-1][ACC_WIDTH-1:0]    acc
);

  for (genvar i = 0; i < ARRAY_W; i++) begin : g_row
    for (genvar j = 0; j < ARRAY_W; j++) begin : g_col
      logic [ACC_WIDTH-1:0] acc_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  acc_q <= '0;
        else if (clr)  acc_q <= '0;
        else if (add)  acc_q <= acc_q + ACC_WIDTH'(sext(64'(in_data[i][j]), 2 * DATA_WIDTH));
      end

      assign acc[i][j] = acc_q;
    end
  end

endmodule

// File: rtl/sys_array_tile_scheduler.sv
// Sequences the systolic array through a K-tiled matrix multiply: per tile it
// requests the operand tile, pulses load_params, waits a fixed gap, holds
// start_comp, waits for the array to go busy and then ready again, and adds
// the array result into a wide accumulator bank.
//   clk, reset_n          : clock, async active-low reset (aborts any job)
//   job_start/job_k_tiles : host job launch (accepted only when idle)
//   job_busy              : high whenever not idle
//   tile_req/tile_idx/tile_ack : operand tile fetch handshake
//   arr_load_params/arr_start_comp/arr_ready/arr_out_data : array control
//   res_valid/res_ack/res_data : accumulated result handshake
//   err_timeout           : sticky, array never completed; cleared by next job
module sys_array_tile_scheduler
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_W    = DEF_ARRAY_W,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LOAD_GAP   = DEF_LOAD_GAP,
  parameter int START_LEN  = DEF_START_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_start,
  input  logic [15:0] job_k_tiles,
  output logic        job_busy,
  output logic        tile_req,
  output logic [15:0] tile_idx,
  input  logic        tile_ack,
  output logic        arr_load_params,
  output logic        arr_start_comp,
  input  logic        arr_ready,
  input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] arr_out_data,
  output logic        res_valid,
  input  logic        res_ack,
  output logic [0:ARRAY_W-1][0:ARRAY_W-1][ACC_WIDTH-1:0]    res_data,
  output logic        err_timeout
);

  // One counter serves GAP, START and WAIT; sized for the largest of them.
  localparam int CW = $clog2(TIMEOUT + LOAD_GAP + START_LEN + 1) + 1;
  localparam logic [CW-1:0] GAP_LAST   = CW'(LOAD_GAP - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_LEN - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   k_tiles, k_n, idx_n;
  logic          busy_seen, seen_n, err_n;
  logic          acc_clr, acc_add;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      k_tiles     <= '0;
      tile_idx    <= '0;
      busy_seen   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      k_tiles     <= k_n;
      tile_idx    <= idx_n;
      busy_seen   <= seen_n;
      err_timeout <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    k_n     = k_tiles;
    idx_n   = tile_idx;
    seen_n  = busy_seen;
    err_n   = err_timeout;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    case (state)
      S_IDLE: if (job_start) begin
        k_n     = job_k_tiles;
        idx_n   = '0;
        err_n   = 1'b0;
        acc_clr = 1'b1;
        state_n = (job_k_tiles == 16'd0) ? S_DONE : S_FETCH;
      end
      S_FETCH: if (tile_ack) state_n = S_LOAD;
      S_LOAD: begin
        // Forget the previous tile's busy phase so its lingering ready
        // cannot complete this tile.
        seen_n  = 1'b0;
        cnt_n   = '0;
        state_n = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = S_START;
        end else cnt_n = cnt + 1'b1;
      end
      S_START: begin
        if (!arr_ready) seen_n = 1'b1;
        if (cnt == START_LAST) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else cnt_n = cnt + 1'b1;
      end
      S_WAIT: begin
        if (arr_ready && busy_seen) state_n = S_ACCUM;
        else if (cnt == WAIT_LAST) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (!arr_ready) seen_n = 1'b1;
        end
      end
      // The array holds arr_out_data while ready, so it is added directly.
      S_ACCUM: begin
        acc_add = 1'b1;
        if (tile_idx == k_tiles - 16'd1) state_n = S_DONE;
        else begin
          idx_n   = tile_idx + 16'd1;
          state_n = S_FETCH;
        end
      end
      S_DONE: if (res_ack) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign job_busy        = (state != S_IDLE);
  assign tile_req        = (state == S_FETCH);
  assign arr_load_params = (state == S_LOAD);
  assign arr_start_comp  = (state == S_START);
  assign res_valid       = (state == S_DONE);

  sys_array_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_W    (ARRAY_W),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .add     (acc_add),
    .in_data (arr_out_data),
    .acc     (res_data)
  );

endmodule

// File: tb/tb_sys_array_tile_scheduler.sv
// Randomized scoreboard bench for sys_array_tile_scheduler. Jobs push their
// expected outcome (sum of tiles, load count, or timeout) into exp_q; a
// monitor pops and compares whenever a result or timeout appears. Behavioural
// models stand in for the operand memory and the array.
module tb_sys_array_tile_scheduler;

  localparam int DW = 8, W = 5, ACC = 24, GAP = 6, SLEN = 6, TMO = 1024;
  localparam int RB = W * W * ACC;

  typedef logic [0:W-1][0:W-1][2*DW-1:0] tile_t;
  typedef logic [0:W-1][0:W-1][ACC-1:0]  res_t;
  typedef struct {
    bit   err;
    int   loads;
    res_t data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        job_start, tile_ack, arr_ready, res_ack;
  logic [15:0] job_k_tiles;
  logic        job_busy, tile_req, arr_load_params, arr_start_comp, res_valid, err_timeout;
  logic [15:0] tile_idx;
  tile_t       arr_out_data;
  res_t        res_data;

  exp_t  exp_q[$];
  tile_t tile_q[$];
  tile_t job_tiles[$];
  int    n_cmp = 0, n_bad = 0;
  int    load_cnt = 0, exp_idx = 0;
  bit    stuck = 1'b0;

  sys_array_tile_scheduler #(
    .DATA_WIDTH (DW), .ARRAY_W (W), .ACC_WIDTH (ACC),
    .LOAD_GAP (GAP), .START_LEN (SLEN), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .job_start (job_start), .job_k_tiles (job_k_tiles), .job_busy (job_busy),
    .tile_req (tile_req), .tile_idx (tile_idx), .tile_ack (tile_ack),
    .arr_load_params (arr_load_params), .arr_start_comp (arr_start_comp),
    .arr_ready (arr_ready), .arr_out_data (arr_out_data),
    .res_valid (res_valid), .res_ack (res_ack), .res_data (res_data),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: element-wise signed sum of all tiles, reduced mod 2^ACC.
  function automatic res_t model_sum();
    res_t r;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        longint s = 0;
        foreach (job_tiles[t]) s += longint'($signed(job_tiles[t][i][j]));
        r[i][j] = ACC'(s);
      end
    return r;
  endfunction

  task automatic fill(input logic [15:0] v, input int n);
    tile_t t;
    job_tiles.delete();
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) t[i][j] = v;
    for (int k = 0; k < n; k++) job_tiles.push_back(t);
  endtask

  task automatic fill_rand(input int n);
    tile_t t;
    job_tiles.delete();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++) t[i][j] = 16'($urandom);
      job_tiles.push_back(t);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  job_busy, 0);
    chk({tag, "_req"},   tile_req, 0);
    chk({tag, "_idx"},   tile_idx, 0);
    chk({tag, "_load"},  arr_load_params, 0);
    chk({tag, "_start"}, arr_start_comp, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_err"},   err_timeout, 0);
    chk({tag, "_data"},  res_data, 0);
  endtask

  task automatic run_job(input int k, input int ack_dly, input bit inject, input bit expect_err);
    exp_t e;
    int   n, bound;
    e.err   = expect_err;
    e.loads = expect_err ? 1 : k;
    e.data  = expect_err ? '0 : model_sum();
    exp_q.push_back(e);
    if (!expect_err) foreach (job_tiles[t]) tile_q.push_back(job_tiles[t]);
    exp_idx = 0;
    @(negedge clk); job_k_tiles = 16'(k); job_start = 1'b1;
    @(negedge clk); job_start = 1'b0;
    chk("err_cleared_on_start", err_timeout, 0);
    if (k == 0) chk("k0_done_next_cycle", res_valid, 1);
    if (inject) begin
      repeat (3) @(negedge clk);
      job_k_tiles = 16'd9; job_start = 1'b1;
      @(negedge clk); job_start = 1'b0;
    end
    bound = 200 + 60 * k + (expect_err ? 2 * TMO : 0);
    n = 0;
    while (!res_valid && !err_timeout && n < bound) begin
      @(negedge clk); n++;
    end
    chk("job_completes_in_bound", n < bound, 1);
    if (expect_err) begin
      chk("timeout_not_early", n >= TMO, 1);
      chk("timeout_err", err_timeout, 1);
      chk("timeout_no_valid", res_valid, 0);
      chk("timeout_idle", job_busy, 0);
    end else begin
      repeat (ack_dly) @(negedge clk);
      res_ack = 1'b1;
      @(negedge clk); res_ack = 1'b0;
      chk("valid_drops_after_ack", res_valid, 0);
      chk("idle_after_ack", job_busy, 0);
    end
  endtask

  // Operand tile memory: acks a request after 0..3 cycles.
  initial begin
    tile_ack = 1'b0;
    forever begin
      @(negedge clk);
      tile_ack = 1'b0;
      if (tile_req) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        tile_ack = tile_req;
      end
    end
  end

  // Array: goes busy on start_comp, finishes 1..5 cycles after it drops and
  // holds the result with ready high until the next start. In stuck mode it
  // never drops ready.
  initial begin
    arr_ready    = 1'b1;
    arr_out_data = '0;
    forever begin
      @(negedge clk);
      if (arr_start_comp && !stuck) begin
        arr_ready = 1'b0;
        while (arr_start_comp) @(negedge clk);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        if (tile_q.size() > 0) arr_out_data = tile_q.pop_front();
        arr_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit   pv = 0, pe = 0, pr = 0;
    exp_t cur;
    cur.err = 0; cur.loads = 0; cur.data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv = 0; pe = 0; pr = 0;
      end else begin
        if (arr_load_params) load_cnt++;
        if (tile_req && !pr) begin
          chk("tile_idx_seq", tile_idx, exp_idx);
          exp_idx++;
        end
        if ((res_valid && !pv) || (err_timeout && !pe)) begin
          if (exp_q.size() == 0) chk("unexpected_outcome", 1, 0);
          else begin
            cur = exp_q.pop_front();
            chk("outcome_is_err", err_timeout, cur.err);
            chk("load_pulses", load_cnt, cur.loads);
          end
          load_cnt = 0;
        end
        if (res_valid) chk("res_data", res_data, cur.data);
        pv = res_valid; pe = err_timeout; pr = tile_req;
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; job_start = 1'b0; job_k_tiles = '0; res_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset_n = 1'b1;

    fill(16'd2, 1);      run_job(1, 5, 0, 0);   // single tile, late ack
    res_ack = 1'b1; repeat (2) @(negedge clk); res_ack = 1'b0;
    chk("stray_ack_busy", job_busy, 0);
    chk("stray_ack_valid", res_valid, 0);
    fill(16'd4, 3);      run_job(3, 1, 0, 0);   // all 12
    fill(16'hFFFF, 2);   run_job(2, 0, 0, 0);   // 0xFFFFFE
    fill(16'h7FFF, 600); run_job(600, 2, 0, 0); // wraps mod 2^24

    stuck = 1'b1; job_tiles.delete();
    run_job(1, 0, 0, 1);
    stuck = 1'b0;
    fill_rand(2);        run_job(2, 0, 0, 0);   // clears err_timeout

    job_tiles.delete();  run_job(0, 2, 0, 0);   // empty job
    fill_rand(3);        run_job(3, 1, 1, 0);   // job_start while busy ignored

    // Asynchronous reset in the middle of START aborts the job.
    fill(16'd3, 2);
    foreach (job_tiles[t]) tile_q.push_back(job_tiles[t]);
    exp_idx = 0;
    @(negedge clk); job_k_tiles = 16'd2; job_start = 1'b1;
    @(negedge clk); job_start = 1'b0;
    n = 0;
    while (!arr_start_comp && n < 200) begin @(negedge clk); n++; end
    chk("reached_start", arr_start_comp, 1);
    #2 reset_n = 1'b0;
    #1 chk_quiet("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    tile_q.delete(); load_cnt = 0; exp_idx = 0;
    fill(16'd3, 2);      run_job(2, 0, 0, 0);   // all 6

    for (int r = 0; r < 6; r++) begin
      int k = $urandom_range(1, 4);
      fill_rand(k);
      run_job(k, $urandom_range(0, 3), 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
